// File: rtl/mux_rr_scheduler_if.sv
// Bundles the requester, MUX and output-port signals of the round-robin MUX scheduler.
// The master modport is the scheduler side. The slave modport is the environment side.
interface mux_rr_scheduler_if #(
  parameter int unsigned NUM_REQ  = 32,
  parameter int unsigned CHOICE_W = 5,
  parameter int unsigned DATA_W   = 5
);
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  ack;
  logic [CHOICE_W-1:0] mux_choice;
  logic                mux_enable;
  logic [DATA_W-1:0]   mux_data;
  logic [DATA_W-1:0]   out_data;
  logic [CHOICE_W-1:0] out_src;
  logic                out_valid;
  logic                out_ready;
  logic                busy;

  modport master (
    input  req, mux_data, out_ready,
    output ack, mux_choice, mux_enable, out_data, out_src, out_valid, busy
  );

  modport slave (
    output req, mux_data, out_ready,
    input  ack, mux_choice, mux_enable, out_data, out_src, out_valid, busy
  );
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler that sequences one shared MUX read path among NUM_REQ requesters.
// Each transfer runs IDLE -> SELECT -> STROBE -> CAPTURE -> DELIVER and ends with a one-cycle
// ack pulse to the granted requester.
module mux_rr_scheduler #(
  parameter int unsigned NUM_REQ  = 32,
  parameter int unsigned CHOICE_W = 5,
  parameter int unsigned DATA_W   = 5
) (
  input logic                 clk,
  input logic                 rst,
  mux_rr_scheduler_if.master  bus
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSelect  = 3'd1;
  localparam logic [2:0] StStrobe  = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StDeliver = 3'd4;

  localparam logic [CHOICE_W-1:0] LastIdx = CHOICE_W'(NUM_REQ - 1);

  logic [2:0]          state_q, state_d;
  logic [CHOICE_W-1:0] ptr_q;
  logic [CHOICE_W-1:0] choice_q;
  logic [DATA_W-1:0]   data_q;
  logic [CHOICE_W-1:0] src_q;
  logic                valid_q;
  logic [NUM_REQ-1:0]  ack_q;

  logic                grant_valid;
  logic [CHOICE_W-1:0] grant_idx;

  // Pick the first pending requester, scanning upward from ptr with wrap-around.
  always_comb begin
    int unsigned         idx;
    logic [CHOICE_W-1:0] idx_c;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_c       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_c = CHOICE_W'(idx);
      if (!grant_valid && bus.req[idx_c]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_c;
      end
    end
  end

  // Next-state logic for the transfer sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (grant_valid) state_d = StSelect;
      StSelect:  state_d = StStrobe;
      StStrobe:  state_d = StCapture;
      StCapture: state_d = StDeliver;
      StDeliver: if (bus.out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State, grant pointer and output-port registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      choice_q <= '0;
      data_q   <= '0;
      src_q    <= '0;
      valid_q  <= 1'b0;
      ack_q    <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= '0;
      // Choice moves only on IDLE->SELECT, so it is stable through the strobe.
      if (state_q == StIdle && grant_valid) begin
        choice_q <= grant_idx;
      end
      if (state_q == StCapture) begin
        data_q  <= bus.mux_data;
        src_q   <= choice_q;
        valid_q <= 1'b1;
      end
      if (state_q == StDeliver && bus.out_ready) begin
        valid_q <= 1'b0;
        ack_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << choice_q;
        ptr_q   <= (choice_q == LastIdx) ? '0 : choice_q + 1'b1;
      end
    end
  end

  assign bus.mux_choice = choice_q;
  assign bus.mux_enable = (state_q == StStrobe);
  assign bus.out_data   = data_q;
  assign bus.out_src    = src_q;
  assign bus.out_valid  = valid_q;
  assign bus.ack        = ack_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Self-checking bench for mux_rr_scheduler: a cycle table for the basic transfer, directed
// corner-case sequences and a randomized run against a transaction-level reference model.
module tb_mux_rr_scheduler;
  localparam int N  = 32;
  localparam int CW = 5;
  localparam int DW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_rr_scheduler_if #(.NUM_REQ(N), .CHOICE_W(CW), .DATA_W(DW)) bif ();

  mux_rr_scheduler #(.NUM_REQ(N), .CHOICE_W(CW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // MUX model: latches the selected word while its enable is high.
  logic [DW-1:0] mux_words [N];
  logic [DW-1:0] mux_q = '0;
  always @(posedge clk) if (bif.mux_enable) mux_q <= mux_words[bif.mux_choice];
  assign bif.mux_data = mux_q;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The choice must never change on a cycle where the strobe is high.
  logic [CW-1:0] prev_choice = '0;
  always @(negedge clk) begin
    if (!rst && bif.mux_enable) check("choice_stable_under_enable", bif.mux_choice, prev_choice);
    prev_choice = bif.mux_choice;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.req = '0;
    bif.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (bif.out_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic          rdy;
    logic [CW-1:0] choice;
    logic          en;
    logic          valid;
    logic [DW-1:0] data;
    logic [CW-1:0] src;
    logic [N-1:0]  ack;
    logic          busy;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit            ok;
    logic [N-1:0]  one;
    logic [DW-1:0] held_data;
    logic [CW-1:0] held_src;
    int            order [6];
    int            counts [N];

    one = 1;
    for (int i = 0; i < N; i++) mux_words[i] = DW'($urandom);
    mux_words[3] = 5'h15;

    // Single request on index 3: cycle-by-cycle expectations from the IDLE grant cycle.
    tbl[0] = '{req: one << 3, rdy: 1, choice: 0, en: 0, valid: 0, data: 0,     src: 0, ack: 0,
               busy: 0};
    tbl[1] = '{req: 0,        rdy: 1, choice: 3, en: 0, valid: 0, data: 0,     src: 0, ack: 0,
               busy: 1};
    tbl[2] = '{req: 0,        rdy: 1, choice: 3, en: 1, valid: 0, data: 0,     src: 0, ack: 0,
               busy: 1};
    tbl[3] = '{req: 0,        rdy: 1, choice: 3, en: 0, valid: 0, data: 0,     src: 0, ack: 0,
               busy: 1};
    tbl[4] = '{req: 0,        rdy: 1, choice: 3, en: 0, valid: 1, data: 5'h15, src: 3, ack: 0,
               busy: 1};
    tbl[5] = '{req: 0,        rdy: 1, choice: 3, en: 0, valid: 0, data: 0,     src: 0,
               ack: one << 3, busy: 0};
    tbl[6] = '{req: 0,        rdy: 1, choice: 3, en: 0, valid: 0, data: 0,     src: 0, ack: 0,
               busy: 0};

    bif.req = '0;
    bif.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_valid", bif.out_valid, 0);
    check("reset_busy", bif.busy, 0);
    check("reset_ack", bif.ack, 0);
    check("reset_enable", bif.mux_enable, 0);
    check("reset_choice", bif.mux_choice, 0);
    check("reset_data", bif.out_data, 0);
    check("reset_src", bif.out_src, 0);
    do_reset();

    // Table-driven single transfer.
    for (int k = 0; k < 7; k++) begin
      bif.req = tbl[k].req;
      bif.out_ready = tbl[k].rdy;
      check($sformatf("tbl%0d_choice", k), bif.mux_choice, tbl[k].choice);
      check($sformatf("tbl%0d_enable", k), bif.mux_enable, tbl[k].en);
      check($sformatf("tbl%0d_valid", k), bif.out_valid, tbl[k].valid);
      check($sformatf("tbl%0d_ack", k), bif.ack, tbl[k].ack);
      check($sformatf("tbl%0d_busy", k), bif.busy, tbl[k].busy);
      if (tbl[k].valid) begin
        check($sformatf("tbl%0d_data", k), bif.out_data, tbl[k].data);
        check($sformatf("tbl%0d_src", k), bif.out_src, tbl[k].src);
      end
      step();
    end

    // Reset while in DELIVER: outputs clear at once, no ack afterwards, pointer back to 0.
    bif.req = one << 3;
    bif.out_ready = 1'b0;
    wait_valid(10, ok);
    check("abort_reach_deliver", ok, 1);
    bif.req = '0;
    rst = 1'b1;
    #1;
    check("abort_valid", bif.out_valid, 0);
    check("abort_busy", bif.busy, 0);
    check("abort_data", bif.out_data, 0);
    check("abort_src", bif.out_src, 0);
    check("abort_choice", bif.mux_choice, 0);
    check("abort_ack", bif.ack, 0);
    step();
    step();
    rst = 1'b0;
    bif.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("abort_no_ack", bif.ack, 0);
      check("abort_idle", bif.busy, 0);
      step();
    end
    bif.req = one | (one << 5);
    wait_valid(10, ok);
    check("abort_next_timeout", ok, 1);
    check("abort_ptr_zero", bif.out_src, 0);
    bif.req = '0;
    step();

    // Three held requesters: grant order wraps 0, 5, 31, 0, 5, 31.
    do_reset();
    order = '{0, 5, 31, 0, 5, 31};
    bif.req = one | (one << 5) | (one << 31);
    bif.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_valid(10, ok);
      check("wrap_timeout", ok, 1);
      check("wrap_src", bif.out_src, order[i]);
      check("wrap_data", bif.out_data, mux_words[order[i]]);
      step();
    end
    bif.req = '0;
    step();

    // Backpressure: output held for 10 cycles, then one ready cycle completes.
    do_reset();
    bif.req = one << 9;
    wait_valid(10, ok);
    check("bp_timeout", ok, 1);
    bif.req = '0;
    held_data = mux_words[9];
    held_src = 9;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_held", bif.out_valid, 1);
      check("bp_data_held", bif.out_data, held_data);
      check("bp_src_held", bif.out_src, held_src);
      check("bp_no_ack", bif.ack, 0);
      step();
    end
    bif.out_ready = 1'b1;
    step();
    bif.out_ready = 1'b0;
    check("bp_ack", bif.ack, one << 9);
    check("bp_idle", bif.busy, 0);
    check("bp_valid_drop", bif.out_valid, 0);
    step();
    check("bp_ack_pulse", bif.ack, 0);

    // req[7] raised and req[2] dropped while busy on 2: 2 completes, then 7 is granted.
    do_reset();
    bif.req = one << 2;
    bif.out_ready = 1'b1;
    step();
    bif.req = one << 7;
    wait_valid(10, ok);
    check("late_timeout_a", ok, 1);
    check("late_src_a", bif.out_src, 2);
    step();
    check("late_ack_a", bif.ack, one << 2);
    wait_valid(10, ok);
    check("late_timeout_b", ok, 1);
    check("late_src_b", bif.out_src, 7);
    bif.req = '0;
    step();
    check("late_ack_b", bif.ack, one << 7);

    // All requesters held: 64 grants in ascending wrap order, each index exactly twice.
    do_reset();
    for (int i = 0; i < N; i++) counts[i] = 0;
    bif.req = '1;
    bif.out_ready = 1'b1;
    for (int g = 0; g < 2 * N; g++) begin
      wait_valid(10, ok);
      check("all_timeout", ok, 1);
      check("all_src", bif.out_src, g % N);
      counts[bif.out_src]++;
      step();
    end
    bif.req = '0;
    for (int i = 0; i < N; i++) check($sformatf("all_count%0d", i), counts[i], 2);
    step();

    // Randomized traffic against a transaction-level model.
    begin
      bit           m_busy;
      int           m_cnt, m_g, m_ptr, m_choice;
      logic [N-1:0] m_ack, r;
      bit           rdy;
      for (int i = 0; i < N; i++) mux_words[i] = DW'($urandom);
      do_reset();
      m_busy = 0; m_cnt = 0; m_g = 0; m_ptr = 0; m_choice = 0; m_ack = '0;
      for (int c = 0; c < 2000; c++) begin
        check("rnd_busy", bif.busy, m_busy);
        check("rnd_ack", bif.ack, m_ack);
        check("rnd_valid", bif.out_valid, m_busy && m_cnt == 4);
        check("rnd_enable", bif.mux_enable, m_busy && m_cnt == 2);
        check("rnd_choice", bif.mux_choice, m_choice);
        if (m_busy && m_cnt == 4) begin
          check("rnd_src", bif.out_src, m_g);
          check("rnd_data", bif.out_data, mux_words[m_g]);
        end
        r = ($urandom_range(0, 3) == 0) ? '0 : ($urandom & $urandom & $urandom);
        rdy = ($urandom_range(0, 3) != 0);
        bif.req = r;
        bif.out_ready = rdy;
        m_ack = '0;
        if (!m_busy) begin
          for (int k = 0; k < N; k++) begin
            if (!m_busy && r[(m_ptr + k) % N]) begin
              m_g = (m_ptr + k) % N;
              m_choice = m_g;
              m_busy = 1;
              m_cnt = 1;
            end
          end
        end else if (m_cnt == 4) begin
          if (rdy) begin
            m_ack = one << m_g;
            m_ptr = (m_g + 1) % N;
            m_busy = 0;
          end
        end else begin
          m_cnt++;
        end
        step();
      end
      bif.req = '0;
      bif.out_ready = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
